// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter slice: FSM state encodings,
// SDRAM command encodings, timing constants and a small run-counter helper.
package sdram_pkg;

    // Arbiter FSM states; the unused encoding 2'b11 falls back to StIdle.
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StBurst   = 2'd1;
    localparam logic [1:0] StRefresh = 2'd2;

    // Controller commands as {RAS#, CAS#, WE#}, with CS# asserted.
    typedef enum logic [2:0] {
        CmdLoadMode  = 3'b000,
        CmdRefresh   = 3'b001,
        CmdPrecharge = 3'b010,
        CmdActive    = 3'b011,
        CmdWrite     = 3'b100,
        CmdRead      = 3'b101,
        CmdBurstTerm = 3'b110,
        CmdNop       = 3'b111
    } sdram_cmd_e;

    // Row cycle time and average refresh interval, in controller clocks.
    localparam int unsigned TRc  = 8;
    localparam int unsigned TRef = 780;

    // Saturating increment for the 4-bit run counter.
    function automatic logic [3:0] run_inc(input logic [3:0] run);
        return (run == 4'hf) ? run : run + 4'd1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Request/grant bundle between the two ports, the refresh timer and the
// SDRAM controller on one side and the port arbiter on the other.
interface sdram_port_arbiter_if;

    logic i_wr_req;
    logic i_rd_req;
    logic i_ref_req;
    logic i_done;
    logic o_start;
    logic o_wrrd;
    logic o_ref_start;
    logic o_busy;
    logic o_err;

    // Requesters and controller side.
    modport master (
        output i_wr_req, i_rd_req, i_ref_req, i_done,
        input  o_start, o_wrrd, o_ref_start, o_busy, o_err
    );

    // Arbiter side.
    modport slave (
        input  i_wr_req, i_rd_req, i_ref_req, i_done,
        output o_start, o_wrrd, o_ref_start, o_busy, o_err
    );

endinterface

// File: rtl/sdram_arb_timeout.sv
// Watchdog for one burst or refresh: loaded to 1 on the start edge, counts
// while the operation is outstanding, flags expiry when it reaches TIMEOUT.
module sdram_arb_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] Limit = 8'(TIMEOUT);

    logic [7:0] cnt_q;

    // Count outstanding cycles; cleared whenever nothing is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= 8'd1;
        end else if (count) begin
            if (cnt_q != 8'hff) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign expired = count && (cnt_q == Limit);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates one SDRAM controller between a write port, a read port and
// auto-refresh. Refresh always wins; otherwise the port that did not own the
// last burst is preferred. Optional macro SDRAM_ARB_RUNLIMIT_EN lets the last
// owner keep the bus for up to MAX_RUN consecutive bursts.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned MAX_RUN = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sdram_port_arbiter_if.slave  bus
);

    if (MAX_RUN < 1 || MAX_RUN > 15) begin : gen_bad_max_run
        $error("sdram_port_arbiter: MAX_RUN must be 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gen_bad_timeout
        $error("sdram_port_arbiter: TIMEOUT must be 2..255");
    end

    logic [1:0] state_q, state_d;
    logic       start_q, start_d;
    logic       ref_start_q, ref_start_d;
    logic       wrrd_q, wrrd_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       last_wr_q, last_wr_d;

    logic       idle;
    logic       grant_ref;
    logic       grant_port;
    logic       pref_wr;
    logic       pick_wr;
    logic       tmo_load;
    logic       tmo_count;
    logic       tmo_expired;

    assign idle       = (state_q == StIdle);
    assign grant_ref  = idle && bus.i_ref_req;
    assign grant_port = idle && !bus.i_ref_req && (bus.i_wr_req || bus.i_rd_req);
    assign pick_wr    = bus.i_wr_req && (pref_wr || !bus.i_rd_req);
    assign tmo_load   = grant_ref || grant_port;
    assign tmo_count  = (state_q == StBurst) || (state_q == StRefresh);

`ifdef SDRAM_ARB_RUNLIMIT_EN
    localparam logic [3:0] MaxRun = 4'(MAX_RUN);

    logic [3:0] run_q, run_d;
    logic       last_req;

    // Keep the last owner while it still asks and its run is short; run 0
    // means no burst since reset, so the write port goes first.
    always_comb begin
        last_req = last_wr_q ? bus.i_wr_req : bus.i_rd_req;
        if (run_q != 4'd0 && run_q < MaxRun && last_req) begin
            pref_wr = last_wr_q;
        end else begin
            pref_wr = !last_wr_q;
        end
    end

    // Consecutive bursts by the same port; restarts at 1 on an owner change.
    always_comb begin
        run_d = run_q;
        if (grant_port) begin
            run_d = (pick_wr == last_wr_q && run_q != 4'd0) ? run_inc(run_q) : 4'd1;
        end
    end

    // Run counter register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    // Strict alternation: whoever did not have the last burst goes next.
    assign pref_wr = !last_wr_q;
`endif

    sdram_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (tmo_load),
        .count   (tmo_count),
        .expired (tmo_expired)
    );

    // Next-state and output decode; i_done beats a coincident timeout.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        ref_start_d = 1'b0;
        wrrd_d      = wrrd_q;
        busy_d      = busy_q;
        err_d       = err_q;
        last_wr_d   = last_wr_q;
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (grant_ref) begin
                    state_d     = StRefresh;
                    ref_start_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (grant_port) begin
                    state_d   = StBurst;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    wrrd_d    = pick_wr;
                    last_wr_d = pick_wr;
                end
            end
            StBurst, StRefresh: begin
                if (bus.i_done) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (tmo_expired) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            ref_start_q <= 1'b0;
            wrrd_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            ref_start_q <= ref_start_d;
            wrrd_q      <= wrrd_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign bus.o_start     = start_q;
    assign bus.o_ref_start = ref_start_q;
    assign bus.o_wrrd      = wrrd_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus pushes the expected
// start/refresh pulses (kind, direction, cycle); a monitor pops and compares.
module tb_sdram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(
        .MAX_RUN (4),
        .TIMEOUT (64)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit is_ref;
        bit wrrd;
        int at;
    } exp_t;
    exp_t exp_q[$];

    bit ctrl_en = 1'b0;
    int ctrl_dly = 8;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit is_ref, input bit wrrd, input int at);
        exp_t e;
        e.is_ref = is_ref;
        e.wrrd   = wrrd;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_start"}, int'(bus.o_start), 0);
        check({name, "_ref_start"}, int'(bus.o_ref_start), 0);
        check({name, "_wrrd"}, int'(bus.o_wrrd), 0);
        check({name, "_busy"}, int'(bus.o_busy), 0);
        check({name, "_err"}, int'(bus.o_err), 0);
    endtask

    task automatic do_reset(input string name);
        rst_n         = 1'b0;
        bus.i_wr_req  = 1'b0;
        bus.i_rd_req  = 1'b0;
        bus.i_ref_req = 1'b0;
        bus.i_done    = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check_outputs_zero(name);
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic end_test(input string name);
        tick(15);
        check({name, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every start or refresh pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_start || bus.o_ref_start) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: start=%0b ref_start=%0b wrrd=%0b cycle=%0d, required no pulse",
                             bus.o_start, bus.o_ref_start, bus.o_wrrd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_ref_start != e.is_ref || bus.o_start == e.is_ref ||
                        (!e.is_ref && bus.o_wrrd != e.wrrd) || cyc != e.at) begin
                        fails++;
                        $display("FAIL pulse: start=%0b ref_start=%0b wrrd=%0b cycle=%0d, required ref=%0b wrrd=%0b cycle=%0d",
                                 bus.o_start, bus.o_ref_start, bus.o_wrrd, cyc, e.is_ref, e.wrrd, e.at);
                    end
                end
            end
        end
    end

    // Controller model: pulse i_done ctrl_dly cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (ctrl_en && (bus.o_start || bus.o_ref_start)) begin
                repeat (ctrl_dly) @(posedge clk);
                #1 bus.i_done = 1'b1;
                @(posedge clk);
                #1 bus.i_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [8:0] pat;

        bus.i_wr_req  = 1'b0;
        bus.i_rd_req  = 1'b0;
        bus.i_ref_req = 1'b0;
        bus.i_done    = 1'b0;

        // Both ports held: alternation (or run-limited runs of four).
`ifdef SDRAM_ARB_RUNLIMIT_EN
        pat = 9'b100001111;
`else
        pat = 9'b101010101;
`endif
        do_reset("rst_alt");
        ctrl_en  = 1'b1;
        ctrl_dly = 8;
        n = cyc;
        bus.i_wr_req = 1'b1;
        bus.i_rd_req = 1'b1;
        for (int k = 0; k < 9; k++) push(1'b0, pat[k], n + 1 + 10 * k);
        drain("alt", 200);
        bus.i_wr_req = 1'b0;
        bus.i_rd_req = 1'b0;
        end_test("alt");

        // Refresh raised mid write burst beats a waiting read.
        do_reset("rst_ref");
        n = cyc;
        bus.i_wr_req = 1'b1;
        push(1'b0, 1'b1, n + 1);
        push(1'b1, 1'b0, n + 11);
        push(1'b0, 1'b0, n + 21);
        tick(1);
        bus.i_wr_req = 1'b0;
        tick(3);
        bus.i_ref_req = 1'b1;
        bus.i_rd_req  = 1'b1;
        tick(7);
        bus.i_ref_req = 1'b0;
        tick(10);
        bus.i_rd_req = 1'b0;
        end_test("refresh");

        // i_done on the exact timeout cycle is a normal completion.
        do_reset("rst_coincide");
        ctrl_dly = 63;
        n = cyc;
        bus.i_rd_req = 1'b1;
        push(1'b0, 1'b0, n + 1);
        tick(1);
        bus.i_rd_req = 1'b0;
        tick(64);
        check("coincide_err", int'(bus.o_err), 0);
        check("coincide_busy", int'(bus.o_busy), 0);
        end_test("coincide");

        // Withheld i_done: error at start+64, then a fresh read restarts.
        ctrl_en = 1'b0;
        n = cyc;
        bus.i_rd_req = 1'b1;
        push(1'b0, 1'b0, n + 1);
        tick(1);
        bus.i_rd_req = 1'b0;
        tick(63);
        check("timeout_busy_before", int'(bus.o_busy), 1);
        check("timeout_err_before", int'(bus.o_err), 0);
        tick(1);
        check("timeout_err", int'(bus.o_err), 1);
        check("timeout_busy_after", int'(bus.o_busy), 0);
        ctrl_en  = 1'b1;
        ctrl_dly = 8;
        bus.i_rd_req = 1'b1;
        push(1'b0, 1'b0, cyc + 1);
        tick(1);
        bus.i_rd_req = 1'b0;
        end_test("timeout");
        check("err_sticky", int'(bus.o_err), 1);

        // One-cycle reset mid write burst; held write wins the first grant.
        do_reset("rst_mid");
        ctrl_en = 1'b0;
        n = cyc;
        bus.i_wr_req = 1'b1;
        push(1'b0, 1'b1, n + 1);
        tick(1);
        bus.i_rd_req = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n   = 1'b1;
        ctrl_en = 1'b1;
        check_outputs_zero("mid_reset");
        push(1'b0, 1'b1, n + 5);
        push(1'b0, 1'b0, n + 15);
        tick(1);
        bus.i_wr_req = 1'b0;
        tick(10);
        bus.i_rd_req = 1'b0;
        end_test("reset_mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
